res_ascii_fmt: RTL and testbench
================================

Name: res_ascii_fmt

Overview:
- Downstream stage of the calculator datapath.
- Captures a 32-bit arithmetic result when the multiplier or ALU pulses done.
- Converts it serially (shift-add-3 double dabble) into decimal ASCII.
- Streams the bytes to the UART transmitter over a valid/ready byte handshake, with an optional minus sign and an optional CR LF terminator.

Parameters:
- EOL_EN, 1, when 1 append CR (0x0D) and LF (0x0A) after the last digit; when 0 end after the last digit.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- res_in  input  32  result word from the arithmetic stage.
- res_valid  input  1  one-cycle capture strobe, wired to the upstream done.
- is_signed  input  1  sampled with res_valid; 1 = interpret res_in as two's complement.
- tx_data  output  8  ASCII byte to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- busy  output  1  high whenever state is not IDLE.
- fmt_done  output  1  one-cycle pulse after the final byte is accepted.
- drop  output  1  one-cycle pulse when res_valid arrives while busy.

Behaviour:
- Reset values: tx_data=0x00, tx_valid=0, busy=0, fmt_done=0, drop=0, state=IDLE, BCD register=0, counters=0. Reset mid-operation aborts immediately; a partial line is not resumed.
- States: IDLE, CONV, SIGN, DIG, CR, LF.
- IDLE:
  - On res_valid=1 at capture edge E0, latch the magnitude and neg = is_signed & res_in[31], then go to CONV.
  - Magnitude is -res_in (32-bit two's complement) when neg=1, else res_in. 0x80000000 signed gives magnitude 2147483648.
  - BCD register (40 bits, 10 digits) is cleared at E0.
- CONV: exactly 32 cycles, one double-dabble iteration per cycle.
  - Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd, bin} left by 1.
  - A 5-bit counter runs 31 down to 0; on the iteration with count=0, go to SIGN if neg, else DIG.
  - The digit pointer is loaded with the index of the most significant nonzero digit, or 0 if all digits are zero.
- Byte states: tx_valid=1 throughout; tx_data is held stable until tx_valid & tx_ready. The first tx_valid cycle follows edge E32. There is no combinational path from tx_ready to tx_valid.
  - SIGN: sends 0x2D ('-'), then goes to DIG.
  - DIG: sends 0x30 + digit[ptr]. When ptr=0, the next state is CR if EOL_EN, else IDLE; otherwise ptr decrements. Leading zeros are suppressed and the value zero prints a single '0'.
  - CR: sends 0x0D, then goes to LF.
  - LF: sends 0x0A, then goes to IDLE.
- Leaving the final byte state to IDLE: fmt_done=1 for one cycle coincident with the return to IDLE; tx_valid=0 that cycle.
- res_valid while busy: the input is ignored, drop pulses one cycle, and the in-flight line is unaffected.
- res_valid in the same cycle as the return to IDLE: it is ignored (state is still busy that cycle), drop pulses.
- Line length is at most 13 bytes ('-', 10 digits, CR, LF).
- Throughput with tx_ready held high: one byte per cycle.
- Minimum line latency, capture to fmt_done, is 32 + bytes + 1 cycles.

Test Plan:
- res_in=12345, is_signed=0, tx_ready=1 -> bytes 0x31 0x32 0x33 0x34 0x35 0x0D 0x0A; first tx_valid 32 cycles after capture; fmt_done one cycle after 0x0A accepted.
- res_in=0 -> 0x30 0x0D 0x0A. res_in=0xFFFFFFFF unsigned -> "4294967295\r\n"; the same value with is_signed=1 -> 0x2D 0x31 0x0D 0x0A.
- res_in=0x80000000 with is_signed=1 -> "-2147483648\r\n" (13 bytes), verifying the negation corner case.
- Backpressure: res_in=907 with tx_ready toggled pseudo-randomly -> exactly 0x39 0x30 0x37 0x0D 0x0A accepted; tx_data and tx_valid remain stable during every stall.
- res_valid pulse during CONV and during DIG -> drop pulses each time; original line unchanged; busy stays high. EOL_EN=0 build with res_in=42 -> bytes 0x34 0x32 only.
- n_rst asserted while sending digit 3 of 12345 -> tx_valid=0 and busy=0 immediately; a following capture of 7 produces a clean "7\r\n".

Source files
------------

// File: rtl/res_ascii_fmt_if.sv
// Result-in / ASCII-byte-out bundle between the arithmetic stage, the formatter and the UART.
// master is the formatter side; slave is the upstream/transmitter side.
interface res_ascii_fmt_if;
    logic [31:0] res_in;
    logic        res_valid;
    logic        is_signed;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        fmt_done;
    logic        drop;

    modport master (
        input  res_in, res_valid, is_signed, tx_ready,
        output tx_data, tx_valid, busy, fmt_done, drop
    );

    modport slave (
        output res_in, res_valid, is_signed, tx_ready,
        input  tx_data, tx_valid, busy, fmt_done, drop
    );
endinterface

// File: rtl/res_ascii_fmt.sv
// Captures a 32-bit result, converts it to decimal with a serial double dabble and
// streams the ASCII line (optional '-', digits, optional CR LF) over valid/ready.
module res_ascii_fmt #(
    parameter bit EOL_EN = 1'b1
) (
    input  logic           clk,
    input  logic           n_rst,
    res_ascii_fmt_if.master bus
);
    localparam int NDIG = 10;

    typedef enum logic [2:0] {IDLE, CONV, SIGN, DIG, CR, LF} state_t;

    typedef struct packed {
        logic        neg;
        logic [31:0] mag;
    } cap_t;

    state_t                state, state_nxt;
    logic [NDIG-1:0][3:0]  bcd, bcd_adj, bcd_nxt;
    logic [4*NDIG-1:0]     adj_flat;
    logic [31:0]           bin;
    logic [4:0]            cnt;
    logic [3:0]            ptr, msd;
    logic                  neg;
    logic [7:0]            tx_data_c;
    logic                  tx_valid_c, busy_c, accept;
    logic                  fmt_done_q, drop_q;
    cap_t                  cap;

    always_comb begin
        cap.neg = bus.is_signed & bus.res_in[31];
        cap.mag = cap.neg ? (~bus.res_in + 32'd1) : bus.res_in;
    end

    // Add-3 correction on every nibble, then the whole {bcd, bin} shifts left by one.
    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_add3
            assign bcd_adj[g] = (bcd[g] >= 4'd5) ? bcd[g] + 4'd3 : bcd[g];
        end
    endgenerate

    assign adj_flat = bcd_adj;
    assign bcd_nxt  = {adj_flat[4*NDIG-2:0], bin[31]};

    // Highest nonzero digit of the final iteration's result; 0 when the value is zero.
    always_comb begin
        msd = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_nxt[i] != 4'd0) msd = 4'(i);
        end
    end

    assign busy_c     = (state != IDLE);
    assign tx_valid_c = (state == SIGN) || (state == DIG) || (state == CR) || (state == LF);
    assign accept     = tx_valid_c & bus.tx_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_data_c = 8'h00;
        case (state)
            IDLE: if (bus.res_valid) state_nxt = CONV;
            CONV: if (cnt == 5'd0) state_nxt = neg ? SIGN : DIG;
            SIGN: begin
                tx_data_c = 8'h2D;
                if (bus.tx_ready) state_nxt = DIG;
            end
            DIG: begin
                tx_data_c = 8'h30 + {4'h0, bcd[ptr]};
                if (bus.tx_ready && ptr == 4'd0) state_nxt = EOL_EN ? CR : IDLE;
            end
            CR: begin
                tx_data_c = 8'h0D;
                if (bus.tx_ready) state_nxt = LF;
            end
            LF: begin
                tx_data_c = 8'h0A;
                if (bus.tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bcd        <= '0;
            bin        <= '0;
            cnt        <= '0;
            ptr        <= '0;
            neg        <= 1'b0;
            fmt_done_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            // Only byte states can fall back to IDLE, so this marks the end of a line.
            fmt_done_q <= busy_c && (state_nxt == IDLE);
            drop_q     <= busy_c && bus.res_valid;
            case (state)
                IDLE: begin
                    if (bus.res_valid) begin
                        bin <= cap.mag;
                        neg <= cap.neg;
                        bcd <= '0;
                        cnt <= 5'd31;
                    end
                end
                CONV: begin
                    bcd <= bcd_nxt;
                    bin <= {bin[30:0], 1'b0};
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                    else             ptr <= msd;
                end
                DIG: begin
                    if (accept && ptr != 4'd0) ptr <= ptr - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_data  = tx_data_c;
    assign bus.tx_valid = tx_valid_c;
    assign bus.busy     = busy_c;
    assign bus.fmt_done = fmt_done_q;
    assign bus.drop     = drop_q;
endmodule

// File: tb/tb_res_ascii_fmt.sv
// Directed bench for res_ascii_fmt: line contents, latency, backpressure, drops, reset abort.
module tb_res_ascii_fmt;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    res_ascii_fmt_if bus();
    res_ascii_fmt_if bus2();

    res_ascii_fmt #(.EOL_EN(1'b1)) dut  (.clk(clk), .n_rst(n_rst), .bus(bus));
    res_ascii_fmt #(.EOL_EN(1'b0)) dut2 (.clk(clk), .n_rst(n_rst), .bus(bus2));

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  rx_q[$];
    int          stall_err, drop_cnt, drop_busy;
    bit          got_done, done_ok;
    logic [7:0]  lfsr = 8'hA5;

    function automatic string hex_q();
        string s = "";
        foreach (rx_q[i]) s = {s, $sformatf("%02h ", rx_q[i])};
        return s;
    endfunction

    function automatic string hex_s(input string e);
        string s = "";
        for (int i = 0; i < e.len(); i++) s = {s, $sformatf("%02h ", e[i])};
        return s;
    endfunction

    function automatic bit line_eq(input string e);
        if (rx_q.size() != e.len()) return 1'b0;
        for (int i = 0; i < e.len(); i++) if (rx_q[i] !== e[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic capture(input logic [31:0] v, input logic s);
        @(negedge clk);
        bus.res_in = v; bus.is_signed = s; bus.res_valid = 1'b1;
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    // Receives one line from bus; optional pseudo-random stalls and a res_valid poke
    // once 'inj' bytes have been accepted. Starts on the current negedge.
    task automatic rx_line(input bit bp, input int inj);
        bit         holding = 1'b0, last_acc = 1'b0, injected = 1'b0, rdy;
        logic [7:0] hold_d = 8'h00;
        int         cyc = 0;
        rx_q.delete();
        stall_err = 0; drop_cnt = 0; drop_busy = 0; got_done = 1'b0; done_ok = 1'b0;
        while (cyc < 400) begin
            bus.res_valid = 1'b0;
            if (bus.drop) begin
                drop_cnt++;
                if (bus.busy) drop_busy++;
            end
            if (bus.fmt_done) begin
                got_done = 1'b1;
                done_ok  = last_acc && !bus.tx_valid;
                break;
            end
            if (holding && (!bus.tx_valid || bus.tx_data !== hold_d)) stall_err++;
            if (inj >= 0 && !injected && rx_q.size() == inj && bus.tx_valid) begin
                bus.res_in = 32'd555; bus.is_signed = 1'b0; bus.res_valid = 1'b1;
                injected = 1'b1;
            end
            rdy = bp ? lfsr[0] : 1'b1;
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus.tx_ready = rdy;
            last_acc = bus.tx_valid && rdy;
            if (last_acc) rx_q.push_back(bus.tx_data);
            holding = bus.tx_valid && !rdy;
            hold_d  = bus.tx_data;
            @(negedge clk);
            cyc++;
        end
        bus.res_valid = 1'b0;
        bus.tx_ready  = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h want 00", bus.tx_data); end
        checks++; if (bus.fmt_done !== 1'b0 || bus.drop !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got fmt_done=%b drop=%b want 0 0", bus.fmt_done, bus.drop);
        end
        checks++; if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got busy=%b tx_valid=%b want 0 0", bus.busy, bus.tx_valid);
        end
    endtask

    task automatic test_basic();
        int lat = 0;
        capture(32'd12345, 1'b0);
        while (!bus.tx_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++; if (lat != 32) begin errors++; $display("FAIL basic_latency: got %0d want 32", lat); end
        rx_line(1'b0, -1);
        checks++; if (!line_eq("12345\015\012")) begin
            errors++; $display("FAIL basic_line: got %s want %s", hex_q(), hex_s("12345\015\012"));
        end
        checks++; if (!done_ok) begin errors++; $display("FAIL basic_done: got seen=%b ok=%b want 1 1", got_done, done_ok); end
    endtask

    task automatic test_values();
        logic [31:0] vals[4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        sgn[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        string       exps[4] = '{"0\015\012", "4294967295\015\012", "-1\015\012", "-2147483648\015\012"};
        for (int i = 0; i < 4; i++) begin
            capture(vals[i], sgn[i]);
            rx_line(1'b0, -1);
            checks++; if (!line_eq(exps[i])) begin
                errors++; $display("FAIL value_line[%0d]: got %s want %s", i, hex_q(), hex_s(exps[i]));
            end
            checks++; if (!done_ok) begin errors++; $display("FAIL value_done[%0d]: got %b want 1", i, done_ok); end
        end
    endtask

    task automatic test_backpressure();
        capture(32'd907, 1'b0);
        rx_line(1'b1, -1);
        checks++; if (!line_eq("907\015\012")) begin
            errors++; $display("FAIL bp_line: got %s want %s", hex_q(), hex_s("907\015\012"));
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
        checks++; if (!done_ok) begin errors++; $display("FAIL bp_done: got %b want 1", done_ok); end
    endtask

    task automatic test_drop();
        capture(32'd12345, 1'b0);
        repeat (5) @(negedge clk);
        bus.res_in = 32'd999; bus.res_valid = 1'b1;
        @(negedge clk);
        bus.res_valid = 1'b0;
        checks++; if (bus.drop !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL drop_conv: got drop=%b busy=%b want 1 1", bus.drop, bus.busy);
        end
        @(negedge clk);
        rx_line(1'b0, 2);
        checks++; if (!line_eq("12345\015\012")) begin
            errors++; $display("FAIL drop_line: got %s want %s", hex_q(), hex_s("12345\015\012"));
        end
        checks++; if (drop_cnt != 1 || drop_busy != 1) begin
            errors++; $display("FAIL drop_dig: got drops=%0d busy_drops=%0d want 1 1", drop_cnt, drop_busy);
        end
    endtask

    task automatic test_edge_drop();
        capture(32'd12345, 1'b0);
        rx_line(1'b0, 6);
        checks++; if (!line_eq("12345\015\012") || !done_ok) begin
            errors++; $display("FAIL edge_line: got %s done=%b want %s done=1", hex_q(), done_ok, hex_s("12345\015\012"));
        end
        checks++; if (drop_cnt != 1) begin errors++; $display("FAIL edge_drop: got %0d want 1", drop_cnt); end
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL edge_ignored: got busy=%b tx_valid=%b want 0 0", bus.busy, bus.tx_valid);
        end
    endtask

    task automatic test_no_eol();
        logic [7:0] q[$];
        bit done = 1'b0;
        @(negedge clk);
        bus2.res_in = 32'd42; bus2.is_signed = 1'b0; bus2.res_valid = 1'b1;
        @(negedge clk);
        bus2.res_valid = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            if (bus2.fmt_done) done = 1'b1;
            else begin
                if (bus2.tx_valid) q.push_back(bus2.tx_data);
                @(negedge clk);
            end
        end
        checks++; if (q.size() != 2 || q[0] !== 8'h34 || q[1] !== 8'h32 || !done) begin
            errors++;
            $display("FAIL no_eol: got n=%0d b0=%02h b1=%02h done=%b want n=2 34 32 done=1",
                     q.size(), (q.size() > 0) ? q[0] : 8'h00, (q.size() > 1) ? q[1] : 8'h00, done);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        capture(32'd12345, 1'b0);
        while (!bus.tx_valid && c < 100) begin @(negedge clk); c++; end
        repeat (2) @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h33) begin
            errors++; $display("FAIL mid_digit3: got valid=%b data=%02h want 1 33", bus.tx_valid, bus.tx_data);
        end
        n_rst = 1'b0;
        #1;
        checks++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got tx_valid=%b busy=%b want 0 0", bus.tx_valid, bus.busy);
        end
        @(negedge clk);
        n_rst = 1'b1;
        capture(32'd7, 1'b0);
        rx_line(1'b0, -1);
        checks++; if (!line_eq("7\015\012") || !done_ok) begin
            errors++; $display("FAIL mid_after: got %s done=%b want %s done=1", hex_q(), done_ok, hex_s("7\015\012"));
        end
    endtask

    initial begin
        bus.res_in = '0;  bus.res_valid = 1'b0;  bus.is_signed = 1'b0;  bus.tx_ready = 1'b1;
        bus2.res_in = '0; bus2.res_valid = 1'b0; bus2.is_signed = 1'b0; bus2.tx_ready = 1'b1;
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_drop();
        test_edge_drop();
        test_no_eol();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
